hist_scan_reader: RTL and testbench
===================================

Name: hist_scan_reader

Overview:
- Reader side of the histogram sig/mag result port.
- Walks every line index: drives hist_addr/hist_lock, waits for the far side's level synchronisers to settle, captures the 32-bit {sig_count, mag_count} word and stores it in a local register bank.
- Checks each count against programmable windows and raises alarms; the host reads the stored bank via rd_addr/rd_data.
- Sits in the control/bus clock domain; the histogram engine runs in the RF domain.

Parameters:
- LINES, 1, number of lines scanned (1..256); addresses 0..LINES-1.
- SETTLE, 8, cycles waited after each addr/lock change before proceeding (>= far-side sync depth x clock ratio).
- VALID_TIMEOUT, 65535, cycles to wait for hist_valid before aborting with an error.
- MAX_RETRY, 3, capture retries on an unstable result word.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a scan when idle, ignored when busy
- hist_valid  in  1  async from RF domain; 2-FF synchronised internally
- hist_result  in  32  async word {sig[31:16], mag[15:0]}
- hist_addr  out  8  line select to histogram
- hist_lock  out  1  1 = far side holds result, 0 = far side tracks addr
- sig_lo, sig_hi  in  16  inclusive allowed window for sig count
- mag_lo, mag_hi  in  16  inclusive allowed window for mag count
- rd_addr  in  8  host read index
- rd_data  out  32  stored word for rd_addr, 1-cycle read latency; 0 if rd_addr >= LINES
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at scan end (also on abort)
- alarm  out  1  some line out of window in the last scan
- alarm_line  out  8  lowest-index failing line
- err_timeout  out  1  last scan aborted on the valid timeout
- err_unstable  out  1  some line exceeded MAX_RETRY

Behaviour:
- Reset: hist_addr=0, hist_lock=0, busy=0, done=0, alarm=0, alarm_line=0, err_*=0, bank cleared, rd_data=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: on start, clear alarm/err flags and alarm_line, set line=0, go to WAIT_VALID.
  - WAIT_VALID: if synced valid=1, go to SETUP. Otherwise count; at VALID_TIMEOUT set err_timeout and go to DONE. The bank keeps its previous contents.
  - SETUP: hist_addr=line, hist_lock=0; hold SETTLE cycles, then go to LOCK.
  - LOCK: hist_lock=1; hold SETTLE cycles, then go to CAPTURE.
  - CAPTURE: register hist_result on two consecutive cycles (A, B).
    - A==B: go to STORE.
    - A!=B: retry++ and return to LOCK, restarting the SETTLE count.
    - retry==MAX_RETRY: set err_unstable and go to STORE with B.
  - STORE: bank[line]=B. Window check, inclusive bounds:
    - sig < sig_lo, sig > sig_hi, mag < mag_lo or mag > mag_hi counts as a failure.
    - On failure set alarm; if this is the first failure of the scan, alarm_line=line.
    - Clear retry, then go to NEXT.
  - NEXT: hist_lock=0. If line==LINES-1 go to DONE, else line++ and go to SETUP.
  - DONE: done=1 for one cycle, busy=0, hist_lock=0, go to IDLE.
- Timing: per-line latency with no retries = 2*SETTLE+4 cycles. busy rises the cycle after start.
- start while busy: ignored, no queueing.
- start and reset in the same cycle: reset wins.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values and the bank cleared.
- Host reads are always allowed, including mid-scan; they may see a mix of new and old words.
- hist_addr is always < LINES; the line counter never wraps past LINES-1.
- hist_result is sampled only in CAPTURE, and is assumed stable only while hist_lock=1 after SETTLE.
- Flags persist until the next accepted start or reset.

Test Plan:
1. LINES=4, SETTLE=8, valid=1, model returns {16'h8000+i, 16'h5000+i} per addr; start -> after 4*(20) cycles done pulses once, bank[0..3]=32'h8000_5000..32'h8003_5003, alarm=0.
2. Windows sig 16'h7F00..16'h8001, line 2 word 16'h8002 -> alarm=1, alarm_line=2. Then move the window so it passes and restart -> alarm=0.
3. valid held 0, VALID_TIMEOUT=100 -> done pulses 103 cycles after start, err_timeout=1, bank unchanged from the prior scan.
4. Model toggles hist_result every cycle on line 1 -> 3 retries, err_unstable=1, scan completes, other lines stored correctly.
5. Reset asserted while in LOCK of line 2 -> next cycle busy=0, hist_lock=0, hist_addr=0, rd_data of bank[0]=0.
6. Second start pulse mid-scan plus rd_addr=200 -> scan unaffected, single done, rd_data=0.

Source files
------------

// File: rtl/hist_scan_reader_if.sv
// Histogram result port: line select and lock toward the RF-domain engine,
// plus the asynchronous valid flag and result word coming back.
interface hist_scan_reader_if;
  logic        hist_valid;
  logic [31:0] hist_result;
  logic [7:0]  hist_addr;
  logic        hist_lock;

  modport master (input hist_valid, hist_result, output hist_addr, hist_lock);
  modport slave  (output hist_valid, hist_result, input hist_addr, hist_lock);
endinterface

// File: rtl/hist_scan_reader.sv
// Reader side of the histogram sig/mag port: scans all lines over the slow
// addr/lock handshake, banks each word locally and window-checks the counts.
module hist_scan_reader #(
  parameter int LINES         = 1,
  parameter int SETTLE        = 8,
  parameter int VALID_TIMEOUT = 65535,
  parameter int MAX_RETRY     = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  hist_scan_reader_if.master hif,
  input  logic [15:0]        i_sig_lo,
  input  logic [15:0]        i_sig_hi,
  input  logic [15:0]        i_mag_lo,
  input  logic [15:0]        i_mag_hi,
  input  logic [7:0]         i_rd_addr,
  output logic [31:0]        o_rd_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_alarm,
  output logic [7:0]         o_alarm_line,
  output logic               o_err_timeout,
  output logic               o_err_unstable
);
  localparam int AW   = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CMAX = (VALID_TIMEOUT > SETTLE) ? VALID_TIMEOUT : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VALID, S_SETUP, S_LOCK, S_CAPTURE, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_line;
  logic [RW-1:0] r_retry;
  logic          r_vld_m, r_vld_s;
  logic [31:0]   r_a, r_b, r_rd_data;
  logic [31:0]   r_bank [LINES];
  logic          r_busy, r_done, r_alarm, r_err_to, r_err_un, r_lock;
  logic [7:0]    r_alarm_line;
  logic          w_settled, w_last, w_cap_b, w_match, w_fail, w_lock_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_settled = (r_cnt == CW'(SETTLE - 1));
    w_last    = (r_line == 8'(LINES - 1));
    w_cap_b   = (r_cnt != '0);
    w_match   = (r_a == hif.hist_result);
    w_fail    = (r_b[31:16] < i_sig_lo) || (r_b[31:16] > i_sig_hi) ||
                (r_b[15:0]  < i_mag_lo) || (r_b[15:0]  > i_mag_hi);
    case (r_state)
      S_IDLE:       if (i_start) w_next = S_WAIT_VALID;
      S_WAIT_VALID: if (r_vld_s) w_next = S_SETUP;
                    else if (r_cnt == CW'(VALID_TIMEOUT)) w_next = S_DONE;
      S_SETUP:      if (w_settled) w_next = S_LOCK;
      S_LOCK:       if (w_settled) w_next = S_CAPTURE;
      // second capture cycle decides: agree, give up, or re-lock and retry
      S_CAPTURE:    if (w_cap_b)
                      w_next = (w_match || r_retry == RW'(MAX_RETRY)) ? S_STORE : S_LOCK;
      S_STORE:      w_next = S_NEXT;
      S_NEXT:       w_next = w_last ? S_DONE : S_SETUP;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    w_lock_nxt = (w_next == S_LOCK) || (w_next == S_CAPTURE) || (w_next == S_STORE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_m      <= 1'b0;
      r_vld_s      <= 1'b0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_retry      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rd_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_alarm      <= 1'b0;
      r_alarm_line <= '0;
      r_err_to     <= 1'b0;
      r_err_un     <= 1'b0;
      r_lock       <= 1'b0;
      for (int i = 0; i < LINES; i++) r_bank[i] <= '0;
    end else begin
      r_vld_m   <= hif.hist_valid;
      r_vld_s   <= r_vld_m;
      // one counter serves every timed state; it restarts on each state change
      r_cnt     <= (w_next != r_state || w_next == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_lock    <= w_lock_nxt;
      r_done    <= (r_state == S_DONE);
      r_rd_data <= ({1'b0, i_rd_addr} < 9'(LINES)) ? r_bank[i_rd_addr[AW-1:0]] : '0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_busy       <= 1'b1;
          r_alarm      <= 1'b0;
          r_alarm_line <= '0;
          r_err_to     <= 1'b0;
          r_err_un     <= 1'b0;
          r_line       <= '0;
          r_retry      <= '0;
        end
        S_WAIT_VALID: if (w_next == S_DONE) r_err_to <= 1'b1;
        S_CAPTURE: begin
          if (!w_cap_b) r_a <= hif.hist_result;
          else begin
            r_b <= hif.hist_result;
            if (!w_match) begin
              if (r_retry == RW'(MAX_RETRY)) r_err_un <= 1'b1;
              else                           r_retry  <= r_retry + 1'b1;
            end
          end
        end
        S_STORE: begin
          r_bank[r_line[AW-1:0]] <= r_b;
          r_retry <= '0;
          if (w_fail) begin
            r_alarm <= 1'b1;
            if (!r_alarm) r_alarm_line <= r_line;
          end
        end
        S_NEXT: if (!w_last) r_line <= r_line + 1'b1;
        S_DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign hif.hist_addr  = r_line;
  assign hif.hist_lock  = r_lock;
  assign o_rd_data      = r_rd_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_alarm        = r_alarm;
  assign o_alarm_line   = r_alarm_line;
  assign o_err_timeout  = r_err_to;
  assign o_err_unstable = r_err_un;
endmodule

// File: tb/tb_hist_scan_reader.sv
// Bench for hist_scan_reader: a far-side histogram model feeds words per line;
// banked words, window alarms, error flags and scan latency are checked.
module tb_hist_scan_reader;
  localparam int LINES    = 4;
  localparam int SETTLE   = 8;
  localparam int VT       = 100;
  localparam int MR       = 3;
  localparam int LINE_LAT = 2*SETTLE + 4;
  localparam int SCAN_LAT = LINES*LINE_LAT + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [15:0] slo, shi, mlo, mhi;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, done, alarm, err_to, err_un;
  logic [7:0]  alarm_line;

  logic        valid_in, unst_en, tog;
  logic [7:0]  unst_addr;
  logic [31:0] words    [LINES];
  logic [31:0] exp_bank [LINES];
  int n_chk = 0, n_err = 0;

  hist_scan_reader_if hif();

  // far side: word per addressed line, optionally flipping every cycle
  assign hif.hist_valid  = valid_in;
  assign hif.hist_result = (unst_en && hif.hist_addr == unst_addr && tog)
                           ? ~words[hif.hist_addr[1:0]] : words[hif.hist_addr[1:0]];
  initial tog = 1'b0;
  always @(posedge clk) tog <= ~tog;

  hist_scan_reader #(.LINES(LINES), .SETTLE(SETTLE), .VALID_TIMEOUT(VT), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .hif(hif),
    .i_sig_lo(slo), .i_sig_hi(shi), .i_mag_lo(mlo), .i_mag_hi(mhi),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy), .o_done(done),
    .o_alarm(alarm), .o_alarm_line(alarm_line),
    .o_err_timeout(err_to), .o_err_unstable(err_un)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: alarm if any word outside inclusive windows, lowest failing index
  function automatic void model(output logic al, output logic [7:0] al_line);
    al = 1'b0; al_line = '0;
    for (int i = 0; i < LINES; i++) begin
      if (words[i][31:16] < slo || words[i][31:16] > shi ||
          words[i][15:0]  < mlo || words[i][15:0]  > mhi) begin
        if (!al) al_line = 8'(i);
        al = 1'b1;
      end
    end
  endfunction

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); rd_addr = a;
    @(posedge clk); #1; d = rd_data;
  endtask

  task automatic check_bank(input string tag, input int skip);
    logic [31:0] d;
    for (int i = 0; i < LINES; i++) begin
      rd(8'(i), d);
      if (i == skip) chk($sformatf("%s_unst%0d", tag, i), 32'(d == exp_bank[i] || d == ~exp_bank[i]), 1);
      else           chk($sformatf("%s_bank%0d", tag, i), d, exp_bank[i]);
    end
    rd(8'(LINES), d);
    chk({tag, "_oob"}, d, 0);
  endtask

  task automatic check_flags(input string tag, input logic al, input logic [7:0] al_line,
                             input logic eto, input logic eun);
    chk({tag, "_alarm"}, 32'(alarm), 32'(al));
    chk({tag, "_aline"}, 32'(alarm_line), 32'(al_line));
    chk({tag, "_etime"}, 32'(err_to), 32'(eto));
    chk({tag, "_eunst"}, 32'(err_un), 32'(eun));
  endtask

  task automatic run_scan(input string tag, input bit dbl, input int exp_lat);
    int lat, nd;
    lat = 0; nd = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; lat = 1;
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    @(negedge clk); start = 1'b0;
    while (nd == 0 && lat < 3000) begin
      @(posedge clk); #1; lat++;
      if (dbl && lat == 30) begin start = 1'b1; rd_addr = 8'd200; end
      if (dbl && lat == 31) start = 1'b0;
      if (done) nd++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk({tag, "_ndone"}, 32'(nd), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        al;
    logic [7:0]  al_line;
    logic [31:0] d;
    reset = 1'b1; start = 1'b0; valid_in = 1'b1; unst_en = 1'b0; unst_addr = 8'd1;
    slo = 16'h0000; shi = 16'hFFFF; mlo = 16'h0000; mhi = 16'hFFFF; rd_addr = 8'd0;
    for (int i = 0; i < LINES; i++) begin words[i] = '0; exp_bank[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(hif.hist_addr), 0);
    chk("rst_lock", 32'(hif.hist_lock), 0);
    chk("rst_rdata", rd_data, 0);
    check_flags("rst", 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);

    // basic scan with known words
    for (int i = 0; i < LINES; i++) begin
      words[i] = {16'h8000 + 16'(i), 16'h5000 + 16'(i)};
      exp_bank[i] = words[i];
    end
    run_scan("t1", 1'b0, SCAN_LAT);
    check_flags("t1", 1'b0, 8'd0, 1'b0, 1'b0);
    check_bank("t1", -1);

    // sig window excludes 8002/8003: lowest failing line is 2
    slo = 16'h7F00; shi = 16'h8001;
    run_scan("t2a", 1'b0, SCAN_LAT);
    check_flags("t2a", 1'b1, 8'd2, 1'b0, 1'b0);
    shi = 16'h8003;
    run_scan("t2b", 1'b0, SCAN_LAT);
    check_flags("t2b", 1'b0, 8'd0, 1'b0, 1'b0);

    // randomized words and windows against the reference model
    for (int r = 0; r < 6; r++) begin
      slo = 16'($urandom_range(0, 16'h5000));     shi = 16'($urandom_range(16'hB000, 16'hFFFF));
      mlo = 16'($urandom_range(0, 16'h5000));     mhi = 16'($urandom_range(16'hB000, 16'hFFFF));
      for (int i = 0; i < LINES; i++) begin
        if ($urandom_range(0, 3) != 0)
          words[i] = {16'($urandom_range(int'(slo), int'(shi))), 16'($urandom_range(int'(mlo), int'(mhi)))};
        else
          words[i] = $urandom;
        exp_bank[i] = words[i];
      end
      model(al, al_line);
      run_scan($sformatf("rnd%0d", r), 1'b0, SCAN_LAT);
      check_flags($sformatf("rnd%0d", r), al, al_line, 1'b0, 1'b0);
      check_bank($sformatf("rnd%0d", r), -1);
    end

    // valid never arrives: timeout abort, bank keeps previous scan
    slo = 16'h0000; shi = 16'hFFFF; mlo = 16'h0000; mhi = 16'hFFFF;
    valid_in = 1'b0;
    for (int i = 0; i < LINES; i++) words[i] = $urandom;
    repeat (4) @(posedge clk);
    run_scan("t3", 1'b0, VT + 3);
    check_flags("t3", 1'b0, 8'd0, 1'b1, 1'b0);
    check_bank("t3", -1);
    valid_in = 1'b1;
    repeat (4) @(posedge clk);

    // line 1 never stable: all retries spent, scan still completes
    for (int i = 0; i < LINES; i++) begin words[i] = $urandom; exp_bank[i] = words[i]; end
    unst_en = 1'b1;
    run_scan("t4", 1'b0, SCAN_LAT + MR*(SETTLE + 2));
    check_flags("t4", 1'b0, 8'd0, 1'b0, 1'b1);
    check_bank("t4", 1);
    unst_en = 1'b0;

    // reset while line 2 is locked
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    chk("t5_lock_pre", 32'(hif.hist_lock), 1);
    chk("t5_addr_pre", 32'(hif.hist_addr), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_lock", 32'(hif.hist_lock), 0);
    chk("t5_addr", 32'(hif.hist_addr), 0);
    check_flags("t5", 1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    rd(8'd0, d);
    chk("t5_bank0", d, 0);
    repeat (4) @(posedge clk);

    // second start mid-scan is ignored; out-of-range read returns 0
    for (int i = 0; i < LINES; i++) begin words[i] = $urandom; exp_bank[i] = words[i]; end
    run_scan("t6", 1'b1, SCAN_LAT);
    chk("t6_rd200", rd_data, 0);
    check_bank("t6", -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
